map_tile_store: RTL and testbench

Tile memory that sits directly upstream of the map display stage. It holds the 21x21 maze as 3-bit tile codes and serves the display stage's map_x/map_y → sprite_type lookups on a dedicated read port. It also provides a request/acknowledge read-modify-write port for game logic, such as eating orbs. It loads the level layout from an external synchronous ROM and tracks the number of remaining orbs.

---
 rtl/map_tile_store.sv | 147 ++++++++++++++
 tb/tb_map_tile_store.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_tile_store.sv
// 21x21 maze tile RAM: loads a level from a synchronous ROM, serves the display stage on a
// dedicated read port, and offers a req/ack read-modify-write port with an orb counter.
module map_tile_store #(
    parameter int unsigned MAP_W  = 21,
    parameter int unsigned MAP_H  = 21,
    parameter int unsigned TILE_W = 3,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              start_load,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TILE_W-1:0] rom_data,
    output logic              busy,
    input  logic [4:0]        disp_x,
    input  logic [4:0]        disp_y,
    output logic [TILE_W-1:0] disp_sprite_type,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [4:0]        gm_x,
    input  logic [4:0]        gm_y,
    input  logic [TILE_W-1:0] gm_wdata,
    output logic              gm_ack,
    output logic [TILE_W-1:0] gm_rdata,
    output logic              gm_err,
    output logic [8:0]        orbs_left,
    output logic              level_clear
);

    localparam int unsigned       NTILES  = MAP_W * MAP_H;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NTILES - 1);
    localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(MAP_W);
    localparam logic [4:0]        W5      = 5'(MAP_W);
    localparam logic [4:0]        H5      = 5'(MAP_H);
    localparam logic [8:0]        ORB_MAX = 9'(NTILES);
    localparam logic [TILE_W-1:0] BIG_ORB = TILE_W'(1);
    localparam logic [TILE_W-1:0] SML_ORB = TILE_W'(2);

    typedef enum logic [1:0] {LOAD, DRAIN, READY} state_t;

    state_t            state;
    logic [TILE_W-1:0] mem [NTILES];
    logic [ADDR_W-1:0] ld_prev;
    logic              ld_valid;

    logic              disp_in, gm_in, accept, game_wr;
    logic [ADDR_W-1:0] disp_addr, gm_addr, mem_waddr;
    logic [TILE_W-1:0] disp_val, gm_old, mem_wdata;
    logic              mem_we;

    function automatic logic is_orb(input logic [TILE_W-1:0] t);
        return (t == BIG_ORB) || (t == SML_ORB);
    endfunction

    assign busy      = (state != READY);
    assign disp_in   = (disp_x < W5) && (disp_y < H5);
    assign gm_in     = (gm_x < W5) && (gm_y < H5);
    assign disp_addr = ADDR_W'(disp_y) * ROW_LEN + ADDR_W'(disp_x);
    assign gm_addr   = ADDR_W'(gm_y) * ROW_LEN + ADDR_W'(gm_x);
    assign disp_val  = disp_in ? mem[disp_addr] : '0;
    assign gm_old    = gm_in ? mem[gm_addr] : '0;
    // start_load wins over a same-cycle request so the aborted access never writes or acks
    assign accept    = (state == READY) && gm_req && !gm_ack && !start_load;
    assign game_wr   = accept && gm_we && gm_in;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_prev;
        mem_wdata = rom_data;
        if ((state == LOAD && ld_valid) || state == DRAIN) begin
            mem_we = 1'b1;
        end else if (game_wr) begin
            mem_we    = 1'b1;
            mem_waddr = gm_addr;
            mem_wdata = gm_wdata;
        end
    end

    always_ff @(posedge clock_50) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            disp_sprite_type <= '0;
        end else begin
            disp_sprite_type <= (state == READY) ? disp_val : '0;
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            rom_addr    <= '0;
            ld_prev     <= '0;
            ld_valid    <= 1'b0;
            orbs_left   <= '0;
            gm_ack      <= 1'b0;
            gm_err      <= 1'b0;
            gm_rdata    <= '0;
            level_clear <= 1'b0;
        end else begin
            gm_ack      <= 1'b0;
            level_clear <= (state == READY) && (orbs_left == '0);
            if (start_load) begin
                state       <= LOAD;
                rom_addr    <= '0;
                ld_valid    <= 1'b0;
                orbs_left   <= '0;
                level_clear <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        // rom_data belongs to the address issued on the previous clock
                        if (ld_valid && is_orb(rom_data)) orbs_left <= orbs_left + 9'd1;
                        ld_prev  <= rom_addr;
                        ld_valid <= 1'b1;
                        if (rom_addr == LAST) state <= DRAIN;
                        else rom_addr <= rom_addr + 1'b1;
                    end
                    DRAIN: begin
                        if (is_orb(rom_data)) orbs_left <= orbs_left + 9'd1;
                        ld_valid <= 1'b0;
                        rom_addr <= '0;
                        state    <= READY;
                    end
                    READY: begin
                        if (accept) begin
                            gm_ack   <= 1'b1;
                            gm_err   <= !gm_in;
                            gm_rdata <= gm_old;
                            if (game_wr) begin
                                if (is_orb(gm_old) && !is_orb(gm_wdata)) begin
                                    if (orbs_left != '0) orbs_left <= orbs_left - 9'd1;
                                end else if (!is_orb(gm_old) && is_orb(gm_wdata)) begin
                                    if (orbs_left != ORB_MAX) orbs_left <= orbs_left + 9'd1;
                                end
                            end
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_tile_store.sv
// Bench for map_tile_store: ROM model, tile/orb reference model and a scoreboard of game responses.
module tb_map_tile_store;

    logic       clock_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start_load = 1'b0;
    logic [8:0] rom_addr;
    logic [2:0] rom_data;
    logic       busy;
    logic [4:0] disp_x = 5'd0, disp_y = 5'd0;
    logic [2:0] disp_sprite_type;
    logic       gm_req = 1'b0, gm_we = 1'b0;
    logic [4:0] gm_x = 5'd0, gm_y = 5'd0;
    logic [2:0] gm_wdata = 3'd0;
    logic       gm_ack, gm_err;
    logic [2:0] gm_rdata;
    logic [8:0] orbs_left;
    logic       level_clear;

    int total = 0;
    int bad = 0;
    logic [3:0] sb[$];
    logic [2:0] model [441];
    int model_orbs = 0;

    map_tile_store dut (
        .clock_50(clock_50), .reset(reset), .start_load(start_load),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy),
        .disp_x(disp_x), .disp_y(disp_y), .disp_sprite_type(disp_sprite_type),
        .gm_req(gm_req), .gm_we(gm_we), .gm_x(gm_x), .gm_y(gm_y), .gm_wdata(gm_wdata),
        .gm_ack(gm_ack), .gm_rdata(gm_rdata), .gm_err(gm_err),
        .orbs_left(orbs_left), .level_clear(level_clear)
    );

    always #5 clock_50 = ~clock_50;

    function automatic logic [2:0] rom_tile(input logic [8:0] a);
        if (a == 9'd0 || a == 9'd440) return 3'b001;
        if (a == 9'd220) return 3'b010;
        return 3'b011;
    endfunction

    always_ff @(posedge clock_50) rom_data <= rom_tile(rom_addr);

    function automatic logic tb_orb(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b010);
    endfunction

    task automatic model_load();
        for (int i = 0; i < 441; i++) model[i] = rom_tile(9'(i));
        model_orbs = 3;
    endtask

    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    // Call #1 after the edge that released reset or sampled start_load.
    task automatic run_load(input string tag);
        int n = 0;
        int seq_bad = 0;
        while (n < 1000) begin
            step();
            n++;
            if (n <= 440 && rom_addr !== 9'(n)) seq_bad++;
            if (!busy) break;
        end
        total++;
        if (n != 442) begin
            bad++;
            $display("FAIL %s_busy_len: got %0d clocks want 442", tag, n);
        end
        total++;
        if (seq_bad != 0) begin
            bad++;
            $display("FAIL %s_rom_addr_seq: %0d wrong addresses want 0", tag, seq_bad);
        end
        total++;
        if (orbs_left !== 9'd3) begin
            bad++;
            $display("FAIL %s_orbs: got %0d want 3", tag, orbs_left);
        end
        step();
        total++;
        if (level_clear !== 1'b0) begin
            bad++;
            $display("FAIL %s_level_clear: got %0b want 0", tag, level_clear);
        end
        model_load();
    endtask

    task automatic game_access(input logic [4:0] x, input logic [4:0] y, input logic we,
                               input logic [2:0] wd, input int exp_lat,
                               input logic pulse_start, input string tag);
        logic [3:0] exp;
        logic [3:0] got;
        logic [2:0] old;
        int lat;
        int a;
        if (pulse_start) model_load();
        a = int'(y) * 21 + int'(x);
        if (x < 5'd21 && y < 5'd21) begin
            old = model[a];
            exp = {1'b0, old};
            if (we) begin
                if (tb_orb(old) && !tb_orb(wd)) model_orbs--;
                else if (!tb_orb(old) && tb_orb(wd)) model_orbs++;
                model[a] = wd;
            end
        end else begin
            exp = 4'b1000;
        end
        sb.push_back(exp);
        gm_req = 1'b1; gm_we = we; gm_x = x; gm_y = y; gm_wdata = wd;
        start_load = pulse_start;
        lat = 0;
        while (lat < 2000) begin
            step();
            lat++;
            start_load = 1'b0;
            if (gm_ack) break;
        end
        gm_req = 1'b0;
        gm_we  = 1'b0;
        exp = sb.pop_front();
        total++;
        if (gm_ack !== 1'b1) begin
            bad++;
            $display("FAIL %s_ack: no ack within %0d clocks", tag, lat);
        end else begin
            got = {gm_err, gm_rdata};
            if (got !== exp) begin
                bad++;
                $display("FAIL %s_resp: got err/rdata %b want %b", tag, got, exp);
            end
            total++;
            if (lat != exp_lat) begin
                bad++;
                $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_lat);
            end
        end
        step();
        total++;
        if (gm_ack !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_pulse: ack still %0b want 0", tag, gm_ack);
        end
        total++;
        if (orbs_left !== 9'(model_orbs)) begin
            bad++;
            $display("FAIL %s_orbs: got %0d want %0d", tag, orbs_left, model_orbs);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [27:0] got;
        got = {busy, orbs_left, gm_ack, gm_err, gm_rdata, disp_sprite_type, level_clear, rom_addr};
        total++;
        if (got !== 28'h8000000) begin
            bad++;
            $display("FAIL %s: got %h want 8000000", tag, got);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset_async");
        step();
        step();
        check_reset_outputs("reset_held");
    endtask

    task automatic test_load();
        disp_x = 5'd5;
        disp_y = 5'd5;
        @(negedge clock_50);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) step();
        total++;
        if (disp_sprite_type !== 3'b000) begin
            bad++;
            $display("FAIL disp_during_busy: got %b want 000", disp_sprite_type);
        end
        // 10 edges consumed here; run_load continues counting from edge 11
        begin
            int n = 10;
            int seq_bad = 0;
            while (n < 1000) begin
                step();
                n++;
                if (n <= 440 && rom_addr !== 9'(n)) seq_bad++;
                if (!busy) break;
            end
            total++;
            if (n != 442) begin
                bad++;
                $display("FAIL load_busy_len: got %0d clocks want 442", n);
            end
            total++;
            if (seq_bad != 0) begin
                bad++;
                $display("FAIL load_rom_addr_seq: %0d wrong addresses want 0", seq_bad);
            end
            total++;
            if (orbs_left !== 9'd3) begin
                bad++;
                $display("FAIL load_orbs: got %0d want 3", orbs_left);
            end
        end
        model_load();
    endtask

    task automatic test_display();
        logic [4:0] xs [6];
        logic [4:0] ys [6];
        xs = '{5'd0, 5'd10, 5'd21, 5'd20, 5'd1, 5'd3};
        ys = '{5'd0, 5'd10, 5'd3, 5'd20, 5'd1, 5'd21};
        for (int i = 0; i < 6; i++) begin
            logic [2:0] exp;
            disp_x = xs[i];
            disp_y = ys[i];
            exp = (xs[i] < 5'd21 && ys[i] < 5'd21) ? model[int'(ys[i]) * 21 + int'(xs[i])] : 3'b000;
            step();
            total++;
            if (disp_sprite_type !== exp) begin
                bad++;
                $display("FAIL disp_%0d_%0d: got %b want %b", xs[i], ys[i], disp_sprite_type, exp);
            end
        end
        total++;
        if (level_clear !== 1'b0) begin
            bad++;
            $display("FAIL level_clear_after_load: got %0b want 0", level_clear);
        end
    endtask

    task automatic test_write_orb();
        disp_x = 5'd10;
        disp_y = 5'd10;
        game_access(5'd10, 5'd10, 1'b1, 3'b000, 1, 1'b0, "eat_small");
        total++;
        if (disp_sprite_type !== 3'b000) begin
            bad++;
            $display("FAIL disp_after_eat: got %b want 000", disp_sprite_type);
        end
    endtask

    task automatic test_level_clear();
        game_access(5'd0, 5'd0, 1'b1, 3'b000, 1, 1'b0, "eat_00");
        game_access(5'd20, 5'd20, 1'b1, 3'b000, 1, 1'b0, "eat_2020");
        total++;
        if (level_clear !== 1'b1) begin
            bad++;
            $display("FAIL level_clear_set: got %0b want 1", level_clear);
        end
        game_access(5'd1, 5'd1, 1'b1, 3'b010, 1, 1'b0, "place_orb");
        total++;
        if (level_clear !== 1'b0) begin
            bad++;
            $display("FAIL level_clear_drop: got %0b want 0", level_clear);
        end
    endtask

    task automatic test_out_of_range();
        // linear 25 would alias tile (4,1) if the range check were missing
        game_access(5'd25, 5'd0, 1'b1, 3'b010, 1, 1'b0, "oor");
        disp_x = 5'd4;
        disp_y = 5'd1;
        step();
        total++;
        if (disp_sprite_type !== model[25]) begin
            bad++;
            $display("FAIL oor_no_write: got %b want %b", disp_sprite_type, model[25]);
        end
    endtask

    task automatic test_req_during_load();
        // start_load edge is 1, busy falls 442 edges later, accept on the next edge
        game_access(5'd1, 5'd1, 1'b0, 3'b000, 444, 1'b1, "req_through_load");
    endtask

    task automatic test_abort_and_restart();
        int acks = 0;
        int guard = 0;
        gm_req = 1'b1; gm_we = 1'b1; gm_x = 5'd0; gm_y = 5'd0; gm_wdata = 3'b000;
        start_load = 1'b1;
        step();
        gm_req = 1'b0; gm_we = 1'b0; start_load = 1'b0;
        while (rom_addr != 9'd200 && guard < 1000) begin
            if (gm_ack) acks++;
            step();
            guard++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL abort_no_ack: got %0d acks want 0", acks);
        end
        total++;
        if (orbs_left !== 9'd1) begin
            bad++;
            $display("FAIL midload_orbs: got %0d want 1", orbs_left);
        end
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        total++;
        if (rom_addr !== 9'd0 || orbs_left !== 9'd0) begin
            bad++;
            $display("FAIL restart: got addr %0d orbs %0d want 0 0", rom_addr, orbs_left);
        end
        run_load("restart");
        disp_x = 5'd0;
        disp_y = 5'd0;
        step();
        total++;
        if (disp_sprite_type !== 3'b001) begin
            bad++;
            $display("FAIL restart_disp00: got %b want 001", disp_sprite_type);
        end
    endtask

    task automatic test_async_reset();
        game_access(5'd1, 5'd1, 1'b0, 3'b000, 1, 1'b0, "pre_reset_read");
        @(posedge clock_50);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_midclock");
        @(negedge clock_50);
        reset = 1'b0;
        #1;
        run_load("after_reset");
    endtask

    initial begin
        test_reset();
        test_load();
        test_display();
        test_write_orb();
        test_level_clear();
        test_out_of_range();
        test_req_during_load();
        test_abort_and_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
